// File: rtl/pipe_pkg.sv
// Shared constants for the ID/EX pipeline slice: default widths, the bit
// positions inside the packed decode control word, and common funct codes.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int CTL_W  = 5;

    // Bit positions in idCtl = {ALUSrc, RegDst, RegWrite, MemRead, MemWrite}
    localparam int CTL_ALUSRC   = 4;
    localparam int CTL_REGDST   = 3;
    localparam int CTL_REGWRITE = 2;
    localparam int CTL_MEMREAD  = 1;
    localparam int CTL_MEMWRITE = 0;

    // R-type function codes that end up in instReg
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding mux. EX/MEM beats MEM/WB beats the latched
// register value; writes to $0 never forward, and nothing forwards while the
// stage is empty.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              en,
    input  logic [RA_W-1:0]   src,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              ex_mem_reg_write,
    input  logic [RA_W-1:0]   ex_mem_rd,
    input  logic [DATA_W-1:0] ex_mem_data,
    input  logic              mem_wb_reg_write,
    input  logic [RA_W-1:0]   mem_wb_rd,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic [DATA_W-1:0] fwd_val
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    // Priority select of the newest in-flight producer for this source register
    always_comb begin
        ex_mem_hit = en && ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == src);
        mem_wb_hit = en && mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == src);
        fwd_val    = reg_val;
        if (ex_mem_hit) begin
            fwd_val = ex_mem_data;
        end else if (mem_wb_hit) begin
            fwd_val = mem_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Latches decoded operands and control, resolves
// RAW hazards by forwarding from EX/MEM and MEM/WB, and raises a load-use
// stall when the instruction in ID needs the result of a load sitting in EX.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RA_W   = pipe_pkg::RA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idValid,
    input  logic [RA_W-1:0]   idRs,
    input  logic [RA_W-1:0]   idRt,
    input  logic [RA_W-1:0]   idRd,
    input  logic [DATA_W-1:0] idReadRs,
    input  logic [DATA_W-1:0] idReadRt,
    input  logic [DATA_W-1:0] idImm,
    input  logic [5:0]        idFunct,
    input  logic [4:0]        idSa,
    input  logic [1:0]        idALUOp,
    input  logic [4:0]        idCtl,
    input  logic              idMemToReg,
    input  logic              flush,
    input  logic              hold,
    input  logic              exMemRegWrite,
    input  logic [RA_W-1:0]   exMemRd,
    input  logic [DATA_W-1:0] exMemAluOut,
    input  logic              memWbRegWrite,
    input  logic [RA_W-1:0]   memWbRd,
    input  logic [DATA_W-1:0] memWbData,
    output logic [DATA_W-1:0] readRs,
    output logic [DATA_W-1:0] outMuxEx,
    output logic [5:0]        instReg,
    output logic [4:0]        sa,
    output logic [1:0]        ALUOp,
    output logic [DATA_W-1:0] storeData,
    output logic [RA_W-1:0]   exDest,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic              exMemToReg,
    output logic              exValid,
    output logic              loadUseStall
);

    logic              valid_q,      valid_d;
    logic [RA_W-1:0]   rs_q,         rs_d;
    logic [RA_W-1:0]   rt_q,         rt_d;
    logic [RA_W-1:0]   rd_q,         rd_d;
    logic [DATA_W-1:0] rs_val_q,     rs_val_d;
    logic [DATA_W-1:0] rt_val_q,     rt_val_d;
    logic [DATA_W-1:0] imm_q,        imm_d;
    logic [5:0]        funct_q,      funct_d;
    logic [4:0]        sa_q,         sa_d;
    logic [1:0]        alu_op_q,     alu_op_d;
    logic [CTL_W-1:0]  ctl_q,        ctl_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              load_use;

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
        .en               (valid_q),
        .src              (rs_q),
        .reg_val          (rs_val_q),
        .ex_mem_reg_write (exMemRegWrite),
        .ex_mem_rd        (exMemRd),
        .ex_mem_data      (exMemAluOut),
        .mem_wb_reg_write (memWbRegWrite),
        .mem_wb_rd        (memWbRd),
        .mem_wb_data      (memWbData),
        .fwd_val          (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
        .en               (valid_q),
        .src              (rt_q),
        .reg_val          (rt_val_q),
        .ex_mem_reg_write (exMemRegWrite),
        .ex_mem_rd        (exMemRd),
        .ex_mem_data      (exMemAluOut),
        .mem_wb_reg_write (memWbRegWrite),
        .mem_wb_rd        (memWbRd),
        .mem_wb_data      (memWbData),
        .fwd_val          (fwd_rt)
    );

    // Load in EX whose rt target is a source of the real, unsquashed ID instruction
    always_comb begin
        load_use = valid_q && ctl_q[CTL_MEMREAD] && (rt_q != '0)
                   && ((rt_q == idRs) || (rt_q == idRt))
                   && idValid && !flush;
    end

    // Next-state selection: hold keeps contents but refreshes operands, then bubble, then load
    always_comb begin
        valid_d      = valid_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        rs_val_d     = rs_val_q;
        rt_val_d     = rt_val_q;
        imm_d        = imm_q;
        funct_d      = funct_q;
        sa_d         = sa_q;
        alu_op_d     = alu_op_q;
        ctl_d        = ctl_q;
        mem_to_reg_d = mem_to_reg_q;
        if (hold) begin
            // Absorb forwarded values so a producer retiring during the stall is not lost
            rs_val_d = fwd_rs;
            rt_val_d = fwd_rt;
        end else if (flush || load_use) begin
            valid_d      = 1'b0;
            ctl_d        = '0;
            mem_to_reg_d = 1'b0;
            funct_d      = '0;
            sa_d         = '0;
            alu_op_d     = '0;
        end else begin
            valid_d      = idValid;
            rs_d         = idRs;
            rt_d         = idRt;
            rd_d         = idRd;
            rs_val_d     = idReadRs;
            rt_val_d     = idReadRt;
            imm_d        = idImm;
            funct_d      = idFunct;
            sa_d         = idSa;
            alu_op_d     = idALUOp;
            ctl_d        = idCtl;
            mem_to_reg_d = idMemToReg;
        end
    end

    // Stage register; reset clears every field so the outputs read zero immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            sa_q         <= '0;
            alu_op_q     <= '0;
            ctl_q        <= '0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rs_val_q     <= rs_val_d;
            rt_val_q     <= rt_val_d;
            imm_q        <= imm_d;
            funct_q      <= funct_d;
            sa_q         <= sa_d;
            alu_op_q     <= alu_op_d;
            ctl_q        <= ctl_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // EX-side outputs; control and destination are qualified by the valid bit
    always_comb begin
        readRs       = fwd_rs;
        storeData    = fwd_rt;
        outMuxEx     = ctl_q[CTL_ALUSRC] ? imm_q : fwd_rt;
        instReg      = funct_q;
        sa           = sa_q;
        ALUOp        = alu_op_q;
        exValid      = valid_q;
        exDest       = valid_q ? (ctl_q[CTL_REGDST] ? rd_q : rt_q) : '0;
        exRegWrite   = valid_q & ctl_q[CTL_REGWRITE];
        exMemRead    = valid_q & ctl_q[CTL_MEMREAD];
        exMemWrite   = valid_q & ctl_q[CTL_MEMWRITE];
        exMemToReg   = valid_q & mem_to_reg_q;
        loadUseStall = load_use;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-instruction vectors
// followed by hand-written load-use, hold, reset and flush sequences.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idValid;
    logic [4:0]  idRs, idRt, idRd;
    logic [31:0] idReadRs, idReadRt, idImm;
    logic [5:0]  idFunct;
    logic [4:0]  idSa;
    logic [1:0]  idALUOp;
    logic [4:0]  idCtl;
    logic        idMemToReg;
    logic        flush, hold;
    logic        exMemRegWrite;
    logic [4:0]  exMemRd;
    logic [31:0] exMemAluOut;
    logic        memWbRegWrite;
    logic [4:0]  memWbRd;
    logic [31:0] memWbData;
    logic [31:0] readRs, outMuxEx, storeData;
    logic [5:0]  instReg;
    logic [4:0]  sa;
    logic [1:0]  ALUOp;
    logic [4:0]  exDest;
    logic        exRegWrite, exMemRead, exMemWrite, exMemToReg, exValid, loadUseStall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .idValid(idValid),
        .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .idReadRs(idReadRs), .idReadRt(idReadRt), .idImm(idImm),
        .idFunct(idFunct), .idSa(idSa), .idALUOp(idALUOp),
        .idCtl(idCtl), .idMemToReg(idMemToReg),
        .flush(flush), .hold(hold),
        .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemAluOut(exMemAluOut),
        .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
        .readRs(readRs), .outMuxEx(outMuxEx), .instReg(instReg), .sa(sa),
        .ALUOp(ALUOp), .storeData(storeData), .exDest(exDest),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exMemToReg(exMemToReg), .exValid(exValid), .loadUseStall(loadUseStall)
    );

    // ctl encodings {ALUSrc,RegDst,RegWrite,MemRead,MemWrite}
    localparam logic [4:0] C_RTYPE = 5'b01100;
    localparam logic [4:0] C_ADDIU = 5'b10100;
    localparam logic [4:0] C_SW    = 5'b10001;
    localparam logic [4:0] C_LW    = 5'b10110;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rdat_rs, rdat_rt, imm;
        logic [5:0]  funct;
        logic [4:0]  sa;
        logic [1:0]  aluop;
        logic [4:0]  ctl;
        logic        mtr;
        logic        em_w;
        logic [4:0]  em_rd;
        logic [31:0] em_d;
        logic        mw_w;
        logic [4:0]  mw_rd;
        logic [31:0] mw_d;
        logic [31:0] e_rs, e_mux, e_store;
        logic [4:0]  e_dest;
        logic [4:0]  e_flags; // {exValid,exRegWrite,exMemRead,exMemWrite,exMemToReg}
        logic [5:0]  e_funct;
        logic [4:0]  e_sa;
        logic [1:0]  e_aluop;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg};
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] drs, input logic [31:0] drt,
                          input logic [31:0] imm, input logic [5:0] fn, input logic [4:0] s,
                          input logic [1:0] op, input logic [4:0] ctl, input logic mtr);
        idValid = v; idRs = rs; idRt = rt; idRd = rd;
        idReadRs = drs; idReadRt = drt; idImm = imm;
        idFunct = fn; idSa = s; idALUOp = op; idCtl = ctl; idMemToReg = mtr;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] md);
        exMemRegWrite = ew; exMemRd = erd; exMemAluOut = ed;
        memWbRegWrite = mw; memWbRd = mrd; memWbData = md;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".readRs"},    readRs,    32'h0);
        check({tag, ".outMuxEx"},  outMuxEx,  32'h0);
        check({tag, ".storeData"}, storeData, 32'h0);
        check({tag, ".exDest"},    {27'h0, exDest}, 32'h0);
        check({tag, ".flags"},     {27'h0, flags()}, 32'h0);
        check({tag, ".instReg"},   {26'h0, instReg}, 32'h0);
        check({tag, ".sa"},        {27'h0, sa}, 32'h0);
        check({tag, ".ALUOp"},     {30'h0, ALUOp}, 32'h0);
        check({tag, ".stall"},     {31'h0, loadUseStall}, 32'h0);
    endtask

    initial begin
        //           v rs rt rd  drs          drt          imm          funct      sa op ctl      mtr  em_w rd d             mw_w rd d              e_rs         e_mux        e_store      dest flags     funct      sa op
        vecs[0] = '{1, 1, 2, 3,  32'h5,       32'h7,       32'h100,     FUNCT_ADDU, 0, 2, C_RTYPE, 0,  0, 0, 32'h0,         0, 0, 32'h0,         32'h5,       32'h7,       32'h7,       3, 5'b11000, FUNCT_ADDU, 0, 2};
        vecs[1] = '{1, 3, 3, 4,  32'hAA,      32'hAA,      32'h0,       FUNCT_ADDU, 0, 2, C_RTYPE, 0,  1, 3, 32'h10,        1, 3, 32'h99,        32'h10,      32'h10,      32'h10,      4, 5'b11000, FUNCT_ADDU, 0, 2};
        vecs[2] = '{1, 3, 3, 4,  32'hAA,      32'hAA,      32'h0,       FUNCT_SUBU, 0, 2, C_RTYPE, 0,  0, 3, 32'h10,        1, 3, 32'h99,        32'h99,      32'h99,      32'h99,      4, 5'b11000, FUNCT_SUBU, 0, 2};
        vecs[3] = '{1, 0, 6, 9,  32'h0,       32'h55,      32'h7FFF,    FUNCT_OR,   0, 0, C_ADDIU, 0,  1, 0, 32'hFFFF_FFFF, 1, 6, 32'h66,        32'h0,       32'h7FFF,    32'h66,      6, 5'b11000, FUNCT_OR,   0, 0};
        vecs[4] = '{1, 1, 2, 0,  32'h11,      32'h44,      32'h4,       FUNCT_AND,  0, 0, C_SW,    0,  0, 1, 32'hDEAD,      1, 2, 32'h22,        32'h11,      32'h4,       32'h22,      2, 5'b10010, FUNCT_AND,  0, 0};
        vecs[5] = '{1, 1, 5, 0,  32'h1000,    32'h0,       32'h8,       FUNCT_SRL,  3, 0, C_LW,    1,  0, 0, 32'h0,         0, 0, 32'h0,         32'h1000,    32'h8,       32'h0,       5, 5'b11101, FUNCT_SRL,  3, 0};
        vecs[6] = '{0, 3, 3, 4,  32'h33,      32'h77,      32'h0,       FUNCT_SLL,  0, 0, C_RTYPE, 0,  1, 3, 32'h44,        0, 0, 32'h0,         32'h33,      32'h77,      32'h77,      0, 5'b00000, FUNCT_SLL,  0, 0};

        // Reset state
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #2;
        check_all_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Table: capture on one edge, then apply forwarding sources and compare
        for (int i = 0; i < 7; i++) begin
            set_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rdat_rs,
                   vecs[i].rdat_rt, vecs[i].imm, vecs[i].funct, vecs[i].sa, vecs[i].aluop,
                   vecs[i].ctl, vecs[i].mtr);
            set_fwd(0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            idValid = 1'b0;
            set_fwd(vecs[i].em_w, vecs[i].em_rd, vecs[i].em_d, vecs[i].mw_w, vecs[i].mw_rd, vecs[i].mw_d);
            #1;
            check($sformatf("v%0d.readRs", i),    readRs,    vecs[i].e_rs);
            check($sformatf("v%0d.outMuxEx", i),  outMuxEx,  vecs[i].e_mux);
            check($sformatf("v%0d.storeData", i), storeData, vecs[i].e_store);
            check($sformatf("v%0d.exDest", i),    {27'h0, exDest},  {27'h0, vecs[i].e_dest});
            check($sformatf("v%0d.flags", i),     {27'h0, flags()}, {27'h0, vecs[i].e_flags});
            check($sformatf("v%0d.instReg", i),   {26'h0, instReg}, {26'h0, vecs[i].e_funct});
            check($sformatf("v%0d.sa", i),        {27'h0, sa},      {27'h0, vecs[i].e_sa});
            check($sformatf("v%0d.ALUOp", i),     {30'h0, ALUOp},   {30'h0, vecs[i].e_aluop});
        end

        // Load-use: LW r5 in EX, consumer rs=5 in ID
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 5, 0, 32'h1000, 32'h0, 32'h8, FUNCT_SLL, 0, 0, C_LW, 1);
        @(posedge clk); #1;
        set_id(1, 5, 2, 6, 32'hBAD, 32'h2, 32'h0, FUNCT_ADDU, 0, 2, C_RTYPE, 0);
        #1;
        check("lu.stall", {31'h0, loadUseStall}, 32'h1);
        @(posedge clk); #1;
        check("lu.bubble_flags", {27'h0, flags()}, 32'h0);
        check("lu.stall_drop", {31'h0, loadUseStall}, 32'h0);
        @(posedge clk); #1;
        set_fwd(0, 0, 0, 1, 5, 32'hCAFE);
        #1;
        check("lu.readRs", readRs, 32'hCAFE);
        check("lu.exDest", {27'h0, exDest}, 32'd6);
        check("lu.flags", {27'h0, flags()}, {27'h0, 5'b11000});

        // Hold for three edges while the MEM/WB producer of r7 retires
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 7, 0, 8, 32'hBAD0, 32'h0, 32'h0, FUNCT_ADDU, 0, 2, C_RTYPE, 0);
        @(posedge clk); #1;
        hold = 1'b1; flush = 1'b1;
        set_id(1, 1, 2, 9, 32'h1, 32'h2, 32'h0, FUNCT_SLL, 4, 2, C_RTYPE, 0);
        set_fwd(0, 0, 0, 1, 7, 32'h1234);
        #1;
        check("hold.fwd", readRs, 32'h1234);
        @(posedge clk); #1;
        set_fwd(0, 0, 0, 0, 0, 0);
        #1;
        check("hold.kept_rs", readRs, 32'h1234);
        check("hold.kept_flags", {27'h0, flags()}, {27'h0, 5'b11000});
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold = 1'b0; flush = 1'b0; idValid = 1'b0;
        #1;
        check("hold.release_rs", readRs, 32'h1234);
        check("hold.release_dest", {27'h0, exDest}, 32'd8);
        check("hold.release_flags", {27'h0, flags()}, {27'h0, 5'b11000});
        check("hold.release_funct", {26'h0, instReg}, {26'h0, FUNCT_ADDU});

        // Asynchronous reset mid-cycle with a valid instruction in the stage
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1;
        rst_n = 1'b1;

        // Flush of a valid SLL produces a bubble
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 2, 9, 32'h0, 32'h3, 32'h0, FUNCT_SLL, 4, 2, C_RTYPE, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; idValid = 1'b0;
        #1;
        check("flush.flags", {27'h0, flags()}, 32'h0);
        check("flush.exDest", {27'h0, exDest}, 32'h0);
        check("flush.instReg", {26'h0, instReg}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
